w_mem_loader: RTL



---
 rtl/w_mem_loader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/w_mem_loader.sv
// w_mem_loader: turns a neuron-major weight stream into writes on the
// per-neuron weight memories of one layer, so weights can be reloaded at run time.
module w_mem_loader #(
    parameter int numWeight    = 30,
    parameter int numNeuron    = 30,
    parameter int dataWidth    = 16,
    parameter int addressWidth = $clog2(numWeight),
    parameter int neuronWidth  = $clog2(numNeuron)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    s_valid,
    input  logic [dataWidth-1:0]    s_data,
    output logic                    s_ready,
    output logic [numNeuron-1:0]    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FINISH
    } state_t;

    localparam logic [addressWidth-1:0] last_weight = addressWidth'(numWeight - 1);
    localparam logic [neuronWidth-1:0]  last_neuron = neuronWidth'(numNeuron - 1);
    localparam logic [numNeuron-1:0]    neuron0_sel = numNeuron'(1);

    state_t                  state;
    state_t                  state_next;
    logic [neuronWidth-1:0]  nc;
    logic [neuronWidth-1:0]  nc_next;
    logic [addressWidth-1:0] wc;
    logic [addressWidth-1:0] wc_next;
    logic                    handshake;
    logic                    abort_load;

    // State and counter register; counters track the word the next handshake writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            nc    <= '0;
            wc    <= '0;
        end else begin
            state <= state_next;
            nc    <= nc_next;
            wc    <= wc_next;
        end
    end

    // Next state, counter advance and status outputs; abort overrides a same-cycle handshake.
    always_comb begin
        state_next = state;
        nc_next    = nc;
        wc_next    = wc;
        s_ready    = (state == LOAD);
        busy       = (state != IDLE);
        done       = (state == FINISH);
        abort_load = (state == LOAD) && abort;
        handshake  = (state == LOAD) && s_valid && !abort;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    nc_next    = '0;
                    wc_next    = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                    nc_next    = '0;
                    wc_next    = '0;
                end else if (s_valid) begin
                    if (wc == last_weight) begin
                        wc_next = '0;
                        if (nc == last_neuron) begin
                            state_next = FINISH;
                            nc_next    = '0;
                        end else begin
                            nc_next = nc + 1'b1;
                        end
                    end else begin
                        wc_next = wc + 1'b1;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
                nc_next    = '0;
                wc_next    = '0;
            end
            default: begin
                state_next = IDLE;
                nc_next    = '0;
                wc_next    = '0;
            end
        endcase
    end

    // Registered write port: one write per accepted word, address/data hold between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen     <= '0;
            wadd    <= '0;
            win     <= '0;
            aborted <= 1'b0;
        end else begin
            wen     <= handshake ? (neuron0_sel << nc) : '0;
            aborted <= abort_load;
            if (handshake) begin
                wadd <= wc;
                win  <= s_data;
            end
        end
    end

endmodule
